// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared widths, opcodes and FSM state encodings for the accumulator core
package acc_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_HLT = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ  = 3'b111;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEMWR  = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - accumulator arithmetic; a is ACC, b is the memory operand
module acc_alu
  import acc_pkg::*;
#(
  parameter int DATA_W = acc_pkg::DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_LDA:  y = b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/acc_core_ctrl.sv
// rtl/acc_core_ctrl.sv - multi-cycle accumulator CPU controller on a unified word memory
module acc_core_ctrl
  import acc_pkg::*;
#(
  parameter int ADDR_W = acc_pkg::ADDR_W,
  parameter int DATA_W = acc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] acc_out
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] alu_y;
  logic [2:0]        ir_op;
  logic [ADDR_W-1:0] ir_addr;

  assign ir_op   = ir_q[DATA_W-1 -: 3];
  assign ir_addr = ir_q[ADDR_W-1:0];

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op (ir_op),
    .a  (acc_q),
    .b  (mdr_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = read_data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_op)
          OP_ADD, OP_SUB, OP_AND, OP_LDA: state_d = S_MEMRD;
          OP_STA: state_d = S_MEMWR;
          OP_JMP: begin
            pc_d    = ir_addr;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (acc_q == '0) pc_d = ir_addr;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEMRD: begin
        mdr_d   = read_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        acc_d   = alu_y;
        state_d = S_FETCH;
      end
      S_MEMWR: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes come from state alone, so an async reset drops a pending write before its edge.
  always_comb begin
    mem_read  = (state_q == S_FETCH) || (state_q == S_MEMRD);
    mem_write = (state_q == S_MEMWR);
    address   = '0;
    if (state_q == S_FETCH) begin
      address = pc_q;
    end else if ((state_q == S_MEMRD) || (state_q == S_MEMWR)) begin
      address = ir_addr;
    end
  end

  assign write_data = acc_q;
  assign acc_out    = acc_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_acc_core_ctrl.sv
// tb/tb_acc_core_ctrl.sv - scoreboard bench: expected memory accesses queued, checked by a monitor
module tb_acc_core_ctrl;

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [15:0] data;
    int          cyc;
  } acc_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [12:0] address;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        busy;
  logic        halted;
  logic [15:0] acc_out;

  logic [15:0] mem [0:8191];
  acc_t        exp_q [$];
  acc_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          base    = 0;
  int          exp_t   = 0;

  acc_core_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy),
    .halted     (halted),
    .acc_out    (acc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign read_data = mem[address];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) mem[address] <= write_data;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (mem_read && mem_write) begin
        n_tests++;
        n_fail++;
        $display("FAIL strobe_excl: mem_read=1 and mem_write=1 at rel cycle %0d", cyc - base);
      end
      n_tests++;
      if (write_data !== acc_out) begin
        n_fail++;
        $display("FAIL wdata_acc: write_data=%0h acc_out=%0h", write_data, acc_out);
      end
      if (mem_read || mem_write) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL access: unexpected wr=%0b addr=%0d at rel cycle %0d", mem_write, address, cyc - base);
        end else begin
          e = exp_q.pop_front();
          if (e.wr !== mem_write || e.addr !== address || e.cyc != cyc - base ||
              (e.wr && e.data !== write_data)) begin
            n_fail++;
            $display("FAIL access: got wr=%0b addr=%0d data=%0h cyc=%0d expected wr=%0b addr=%0d data=%0h cyc=%0d",
                     mem_write, address, write_data, cyc - base, e.wr, e.addr, e.data, e.cyc);
          end
        end
      end else begin
        n_tests++;
        if (address !== 13'd0) begin
          n_fail++;
          $display("FAIL addr_idle: address=%0d expected 0 at rel cycle %0d", address, cyc - base);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic wr, input int a, input int d, input int c);
    acc_t x;
    x.wr   = wr;
    x.addr = a[12:0];
    x.data = d[15:0];
    x.cyc  = c;
    exp_q.push_back(x);
  endtask

  // Expected access pattern per instruction class: fetch, then operand access two cycles later.
  task automatic x_mem(input int pc, input int a);
    push(1'b0, pc, 0, exp_t);
    push(1'b0, a, 0, exp_t + 2);
    exp_t += 4;
  endtask

  task automatic x_st(input int pc, input int a, input int d);
    push(1'b0, pc, 0, exp_t);
    push(1'b1, a, d, exp_t + 2);
    exp_t += 3;
  endtask

  task automatic x_jmp(input int pc);
    push(1'b0, pc, 0, exp_t);
    exp_t += 2;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_read"}, mem_read, 0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_address"}, address, 0);
    check({tag, "_write_data"}, write_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_acc_out"}, acc_out, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_t = 0;
    @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    base  = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string name, input int exp_halt, input bit poke);
    do_start();
    while (!halted && (cyc - base) < 300) begin
      start = poke && ((cyc - base) == 10);
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_halt_cyc"}, cyc - base, exp_halt);
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] <= 16'h0000;
    #12;
    check_outputs_zero("reset");

    // Sum program: LDA 500, ADD 501..509, STA 800, HLT
    mem[0] <= 16'h81F4;
    for (int i = 1; i <= 9; i++) mem[i] <= 16'(500 + i);
    mem[10] <= 16'hA320;
    mem[11] <= 16'h6000;
    for (int i = 500; i <= 509; i++) mem[i] <= 16'd2;
    mem[506] <= 16'd3;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_wait_busy", busy, 0);
    x_mem(0, 500);
    for (int i = 1; i <= 9; i++) x_mem(i, 500 + i);
    x_st(10, 800, 21);
    x_jmp(11);
    run("sum", 45, 1'b1);
    check("sum_mem800", mem[800], 16'd21);
    check("sum_acc", acc_out, 16'd21);
    check("sum_halted", halted, 1);
    check("sum_busy", busy, 0);
    repeat (3) @(negedge clk);
    do_start();
    repeat (3) @(negedge clk);
    check("halt_terminal", halted, 1);
    check("halt_terminal_drain", exp_q.size(), 0);

    // Wrap-around: FFFF+1, 0-1, then AND mask
    do_reset();
    mem[0]   <= 16'h8064;
    mem[1]   <= 16'h0065;
    mem[2]   <= 16'hA066;
    mem[3]   <= 16'h2067;
    mem[4]   <= 16'hA068;
    mem[5]   <= 16'h4069;
    mem[6]   <= 16'hA06A;
    mem[7]   <= 16'h6000;
    mem[100] <= 16'hFFFF;
    mem[101] <= 16'h0001;
    mem[102] <= 16'h5A5A;
    mem[103] <= 16'h0001;
    mem[105] <= 16'h0F0F;
    x_mem(0, 100);
    x_mem(1, 101);
    x_st(2, 102, 16'h0000);
    x_mem(3, 103);
    x_st(4, 104, 16'hFFFF);
    x_mem(5, 105);
    x_st(6, 106, 16'h0F0F);
    x_jmp(7);
    run("wrap", 27, 1'b0);
    check("wrap_add", mem[102], 16'h0000);
    check("wrap_sub", mem[104], 16'hFFFF);
    check("wrap_acc", acc_out, 16'h0F0F);

    // JZ taken at ACC=0, JMP 8191 wraps PC to 0, JZ not taken at ACC=5
    do_reset();
    mem[0]    <= 16'hE014;
    mem[1]    <= 16'h6000;
    mem[20]   <= 16'hDFFF;
    mem[8191] <= 16'h8032;
    mem[50]   <= 16'd5;
    x_jmp(0);
    x_jmp(20);
    x_mem(8191, 50);
    x_jmp(0);
    x_jmp(1);
    run("jump", 12, 1'b0);
    check("jump_acc", acc_out, 16'd5);

    // Reset pulled inside MEMWR before its write edge
    do_reset();
    mem[0]  <= 16'h8046;
    mem[1]  <= 16'hA047;
    mem[70] <= 16'h1234;
    mem[71] <= 16'hBEEF;
    x_mem(0, 70);
    push(1'b0, 1, 0, 4);
    do_start();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      found = mem_write;
    end
    check("abort_memwr_seen", found, 1);
    #1;
    rst = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_mem71", mem[71], 16'hBEEF);
    check("abort_idle", busy, 0);
    check("abort_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_core_ctrl.md
ACC_CORE_CTRL -- requirements
Module: acc_core_ctrl

Interface
REQ-001 The parameter ADDR_W SHALL default to 13 and give the word-address width.
REQ-002 The parameter DATA_W SHALL default to 16 and give the memory word and accumulator width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that leaves IDLE and begins execution at PC=0.
REQ-006 mem_read  output  1  read strobe to the unified memory; read_data is combinational and valid in the same cycle.
REQ-007 mem_write  output  1  write strobe; the memory captures write_data on the next rising clk edge.
REQ-008 address  output  ADDR_W  word address to memory.
REQ-009 write_data  output  DATA_W  store data, always equal to ACC.
REQ-010 read_data  input  DATA_W  memory read data.
REQ-011 busy  output  1  high in every state except IDLE and HALT.
REQ-012 halted  output  1  high in HALT.
REQ-013 acc_out  output  DATA_W  accumulator value, for debug.

Function
REQ-014 Instruction word SHALL be {op[15:13], addr[12:0]}; opcodes: 000 ADD, 001 SUB, 010 AND, 011 HLT, 100 LDA, 101 STA, 110 JMP, 111 JZ.
REQ-015 The FSM SHALL have states IDLE, FETCH, DECODE, MEMRD, EXEC, MEMWR, HALT.
REQ-016 IDLE: the outputs SHALL be inactive; start=1 SHALL load PC=0 and move to FETCH; start is ignored in every other state.
REQ-017 FETCH: mem_read=1, address=PC, IR<=read_data, PC<=PC+1 modulo 2^13 (8191 wraps to 0), next state DECODE.
REQ-018 DECODE: no memory strobe. ADD/SUB/AND/LDA go to MEMRD; STA goes to MEMWR; JMP sets PC<=addr and goes to FETCH; JZ sets PC<=addr when ACC==0, otherwise leaves PC, then goes to FETCH; HLT goes to HALT.
REQ-019 MEMRD: mem_read=1, address=IR.addr, MDR<=read_data, next state EXEC.
REQ-020 EXEC: ACC updates, with no memory strobe, then next state FETCH. ADD: ACC+MDR modulo 2^16. SUB: ACC-MDR modulo 2^16. AND: ACC&MDR. LDA: ACC=MDR.
REQ-021 MEMWR: mem_write=1, address=IR.addr, write_data=ACC, next state FETCH.
REQ-022 Latency SHALL be 4 cycles for ADD/SUB/AND/LDA, 3 cycles for STA, and 2 cycles for JMP/JZ, counting from FETCH entry to the next FETCH entry.
REQ-023 mem_read and mem_write SHALL never be high in the same cycle; both SHALL be 0 in IDLE, DECODE, EXEC and HALT.
REQ-024 address SHALL be 0 in every state that has no strobe.
REQ-025 HALT SHALL be terminal until rst is asserted.
REQ-026 The outputs SHALL be decoded from the state register and datapath registers only, with no input-to-output combinational path except through read_data capture.

Reset
REQ-027 rst low SHALL immediately force state=IDLE and PC, IR, MDR, ACC=0, with no clock edge needed.
REQ-028 During reset the outputs SHALL be mem_read=0, mem_write=0, address=0, write_data=0, busy=0, halted=0, acc_out=0.
REQ-029 Reset asserted mid-instruction, including during MEMWR, SHALL abort the instruction; a write whose edge has not yet occurred SHALL NOT be issued.
REQ-030 After reset is released, the block SHALL wait in IDLE for start.

Structure
REQ-031 Opcode constants, state encodings and ADDR_W/DATA_W defaults SHALL live in the shared package acc_pkg.
REQ-032 Arithmetic SHALL live in one sub-module, acc_alu, with inputs op, a, b and output y; the FSM and registers stay in acc_core_ctrl.

Verification
REQ-033 Program: LDA 500, ADD 501..509 (memory holds 2 ×9 and 3 at 506), STA 800, HLT -> memory[800]=21, halted=1, and exactly 4+9×4+3+2=45 cycles from the first FETCH to HALT entry.
REQ-034 ACC=0xFFFF, ADD of a word holding 1 -> ACC=0x0000. SUB of 1 from ACC=0 -> ACC=0xFFFF.
REQ-035 JZ 20 with ACC=0 -> the next FETCH address is 20. JZ 20 with ACC=5 -> the next FETCH address is PC+1.
REQ-036 JMP 8191 to a non-jump instruction -> the following FETCH address is 0 (PC wrap).
REQ-037 rst pulled low in the MEMWR cycle before the clock edge -> target memory word unchanged, all outputs 0, and start is required to run again.
REQ-038 A start pulse while busy -> no effect on PC or state. Assertion check: mem_read&&mem_write is never 1.
